// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: opcodes, states,
// datapath mux selects and the control word driven to the datapath.
package mips_ctrl_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned STATE_W = 4;
    localparam int unsigned SEL_W   = 2;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

    typedef enum logic [STATE_W-1:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        IEXEC  = 4'd9,
        IWB    = 4'd10,
        JUMP   = 4'd11
    } state_t;

    localparam logic [SEL_W-1:0] ALU_ADD   = 2'b00;
    localparam logic [SEL_W-1:0] ALU_SUB   = 2'b01;
    localparam logic [SEL_W-1:0] ALU_FUNCT = 2'b10;
    localparam logic [SEL_W-1:0] ALU_IOP   = 2'b11;

    localparam logic [SEL_W-1:0] SRCB_B       = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_FOUR    = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_IMM     = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
    localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic             pc_write;
        logic             pc_write_beq;
        logic             pc_write_bne;
        logic             iord;
        logic             mem_read;
        logic             mem_write;
        logic             ir_write;
        logic             mem_to_reg;
        logic             reg_dst;
        logic             reg_write;
        logic             alu_src_a;
        logic [SEL_W-1:0] alu_src_b;
        logic [SEL_W-1:0] alu_op;
        logic [SEL_W-1:0] pc_source;
        logic             ext_zero;
        logic             illegal;
    } ctrl_t;

    // Logical immediates are zero-extended; arithmetic ones are sign-extended.
    function automatic logic op_zext(input logic [OP_W-1:0] op);
        return (op == OP_ANDI) || (op == OP_ORI);
    endfunction

    function automatic logic op_legal(input logic [OP_W-1:0] op);
        case (op)
            OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI,
            OP_SLTI, OP_ANDI, OP_ORI, OP_LW, OP_SW: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational decode of the current FSM state (plus op / mem_ready where a
// state depends on them) into the datapath control word.
module mc_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t          state,
    input  logic [OP_W-1:0] op,
    input  logic            mem_ready,
    input  logic            ext_hold,
    output ctrl_t           ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.iord      = 1'b0;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            DECODE: begin
                // ALU precomputes the branch target while the opcode dispatches
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALU_ADD;
                ctrl.ext_zero  = 1'b0;
                ctrl.illegal   = !op_legal(op);
            end
            MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
                ctrl.ext_zero  = 1'b0;
            end
            MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_dst    = 1'b0;
            end
            MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_FUNCT;
            end
            ALUWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.mem_to_reg = 1'b0;
            end
            BRANCH: begin
                ctrl.alu_src_a    = 1'b1;
                ctrl.alu_src_b    = SRCB_B;
                ctrl.alu_op       = ALU_SUB;
                ctrl.pc_source    = PCSRC_ALUOUT;
                ctrl.pc_write_beq = (op == OP_BEQ);
                ctrl.pc_write_bne = (op == OP_BNE);
            end
            IEXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_IOP;
                ctrl.ext_zero  = op_zext(op);
            end
            IWB: begin
                // Extender mode comes from the IEXEC capture, not the live op
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b0;
                ctrl.alu_src_b  = SRCB_IMM;
                ctrl.ext_zero   = ext_hold;
            end
            JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS datapath: state register and
// next-state sequencing; the control word is decoded by mc_ctrl_outdec.
module multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    op,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_beq,
    output logic               pc_write_bne,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [SEL_W-1:0]   alu_src_b,
    output logic [SEL_W-1:0]   alu_op,
    output logic [SEL_W-1:0]   pc_source,
    output logic               ext_zero,
    output logic               illegal,
    output logic [STATE_W-1:0] state
);

    state_t cur_state;
    logic   ext_hold;
    ctrl_t  ctrl;
    ctrl_t  ctrl_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= FETCH;
            ext_hold  <= 1'b0;
        end else begin
            case (cur_state)
                FETCH:  if (mem_ready) cur_state <= DECODE;
                DECODE: begin
                    case (op)
                        OP_LW, OP_SW:                        cur_state <= MEMADR;
                        OP_RTYPE:                            cur_state <= EXEC;
                        OP_BEQ, OP_BNE:                      cur_state <= BRANCH;
                        OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:   cur_state <= IEXEC;
                        OP_J:                                cur_state <= JUMP;
                        default:                             cur_state <= FETCH;
                    endcase
                end
                MEMADR: cur_state <= (op == OP_SW) ? MEMWR : MEMRD;
                MEMRD:  if (mem_ready) cur_state <= MEMWB;
                MEMWB:  cur_state <= FETCH;
                MEMWR:  if (mem_ready) cur_state <= FETCH;
                EXEC:   cur_state <= ALUWB;
                ALUWB:  cur_state <= FETCH;
                BRANCH: cur_state <= FETCH;
                IEXEC: begin
                    cur_state <= IWB;
                    ext_hold  <= op_zext(op);
                end
                IWB:     cur_state <= FETCH;
                JUMP:    cur_state <= FETCH;
                default: cur_state <= FETCH;
            endcase
        end
    end

    mc_ctrl_outdec u_outdec (
        .state     (cur_state),
        .op        (op),
        .mem_ready (mem_ready),
        .ext_hold  (ext_hold),
        .ctrl      (ctrl)
    );

    // Reset squashes every strobe in the same cycle, including a pending write.
    assign ctrl_q = reset ? '0 : ctrl;

    assign pc_write     = ctrl_q.pc_write;
    assign pc_write_beq = ctrl_q.pc_write_beq;
    assign pc_write_bne = ctrl_q.pc_write_bne;
    assign iord         = ctrl_q.iord;
    assign mem_read     = ctrl_q.mem_read;
    assign mem_write    = ctrl_q.mem_write;
    assign ir_write     = ctrl_q.ir_write;
    assign mem_to_reg   = ctrl_q.mem_to_reg;
    assign reg_dst      = ctrl_q.reg_dst;
    assign reg_write    = ctrl_q.reg_write;
    assign alu_src_a    = ctrl_q.alu_src_a;
    assign alu_src_b    = ctrl_q.alu_src_b;
    assign alu_op       = ctrl_q.alu_op;
    assign pc_source    = ctrl_q.pc_source;
    assign ext_zero     = ctrl_q.ext_zero;
    assign illegal      = ctrl_q.illegal;
    assign state        = reset ? STATE_W'(0) : cur_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle stimulus and expected
// control words are queued together and compared as each cycle completes.
module tb_multicycle_ctrl;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic       mem_ready;
    logic       pc_write, pc_write_beq, pc_write_bne, iord, mem_read, mem_write;
    logic       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       ext_zero, illegal;
    logic [3:0] state;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [5:0] O_R    = 6'b000000;
    localparam logic [5:0] O_J    = 6'b000010;
    localparam logic [5:0] O_BEQ  = 6'b000100;
    localparam logic [5:0] O_BNE  = 6'b000101;
    localparam logic [5:0] O_ADDI = 6'b001000;
    localparam logic [5:0] O_SLTI = 6'b001010;
    localparam logic [5:0] O_ORI  = 6'b001101;
    localparam logic [5:0] O_LW   = 6'b100011;
    localparam logic [5:0] O_SW   = 6'b101011;
    localparam logic [5:0] O_BAD  = 6'b111111;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, pcb, pcn, iord, mrd, mwr, irw, m2r, rdst, rw, asa;
        logic [1:0] asb, aop, psrc;
        logic       ez, ill;
    } obs_t;

    typedef struct packed {
        logic [5:0] op;
        logic       rdy;
        logic       rst;
    } stim_t;

    localparam obs_t E_ZERO    = '0;
    localparam obs_t E_FETCH   = '{st: 4'd0, mrd: 1'b1, irw: 1'b1, pcw: 1'b1, asb: 2'b01, default: '0};
    localparam obs_t E_FSTALL  = '{st: 4'd0, mrd: 1'b1, asb: 2'b01, default: '0};
    localparam obs_t E_DECODE  = '{st: 4'd1, asb: 2'b11, default: '0};
    localparam obs_t E_DEC_ILL = '{st: 4'd1, asb: 2'b11, ill: 1'b1, default: '0};
    localparam obs_t E_MEMADR  = '{st: 4'd2, asa: 1'b1, asb: 2'b10, default: '0};
    localparam obs_t E_MEMRD   = '{st: 4'd3, mrd: 1'b1, iord: 1'b1, default: '0};
    localparam obs_t E_MEMWB   = '{st: 4'd4, rw: 1'b1, m2r: 1'b1, default: '0};
    localparam obs_t E_MEMWR   = '{st: 4'd5, mwr: 1'b1, iord: 1'b1, default: '0};
    localparam obs_t E_EXEC    = '{st: 4'd6, asa: 1'b1, aop: 2'b10, default: '0};
    localparam obs_t E_ALUWB   = '{st: 4'd7, rw: 1'b1, rdst: 1'b1, default: '0};
    localparam obs_t E_BEQ     = '{st: 4'd8, asa: 1'b1, aop: 2'b01, psrc: 2'b01, pcb: 1'b1, default: '0};
    localparam obs_t E_BNE     = '{st: 4'd8, asa: 1'b1, aop: 2'b01, psrc: 2'b01, pcn: 1'b1, default: '0};
    localparam obs_t E_IEX_Z   = '{st: 4'd9, asa: 1'b1, asb: 2'b10, aop: 2'b11, ez: 1'b1, default: '0};
    localparam obs_t E_IEX_S   = '{st: 4'd9, asa: 1'b1, asb: 2'b10, aop: 2'b11, default: '0};
    localparam obs_t E_IWB_Z   = '{st: 4'd10, rw: 1'b1, asb: 2'b10, ez: 1'b1, default: '0};
    localparam obs_t E_IWB_S   = '{st: 4'd10, rw: 1'b1, asb: 2'b10, default: '0};
    localparam obs_t E_JUMP    = '{st: 4'd11, pcw: 1'b1, psrc: 2'b10, default: '0};

    stim_t stq[$];
    obs_t  expq[$];

    multicycle_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .op           (op),
        .mem_ready    (mem_ready),
        .pc_write     (pc_write),
        .pc_write_beq (pc_write_beq),
        .pc_write_bne (pc_write_bne),
        .iord         (iord),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .ir_write     (ir_write),
        .mem_to_reg   (mem_to_reg),
        .reg_dst      (reg_dst),
        .reg_write    (reg_write),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .pc_source    (pc_source),
        .ext_zero     (ext_zero),
        .illegal      (illegal),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t sample();
        obs_t o;
        o.st   = state;
        o.pcw  = pc_write;
        o.pcb  = pc_write_beq;
        o.pcn  = pc_write_bne;
        o.iord = iord;
        o.mrd  = mem_read;
        o.mwr  = mem_write;
        o.irw  = ir_write;
        o.m2r  = mem_to_reg;
        o.rdst = reg_dst;
        o.rw   = reg_write;
        o.asa  = alu_src_a;
        o.asb  = alu_src_b;
        o.aop  = alu_op;
        o.psrc = pc_source;
        o.ez   = ext_zero;
        o.ill  = illegal;
        return o;
    endfunction

    task automatic push(input logic [5:0] o, input logic r, input logic rs, input obs_t e);
        stq.push_back('{op: o, rdy: r, rst: rs});
        expq.push_back(e);
    endtask

    // Apply one cycle of stimulus on the falling edge and settle.
    task automatic drive(input stim_t s);
        @(negedge clk);
        op        = s.op;
        mem_ready = s.rdy;
        reset     = s.rst;
        #1;
    endtask

    task automatic test_reset();
        obs_t got, exp;
        int   cyc = 0;
        push(O_R, 1'b1, 1'b1, E_ZERO);
        push(O_R, 1'b1, 1'b1, E_ZERO);
        push(O_R, 1'b1, 1'b0, E_FETCH);
        push(O_R, 1'b1, 1'b0, E_DECODE);
        push(O_R, 1'b1, 1'b0, E_EXEC);
        push(O_R, 1'b1, 1'b0, E_ALUWB);
        while (expq.size() > 0) begin
            drive(stq.pop_front());
            exp = expq.pop_front();
            got = sample();
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL reset_rtype cycle %0d: got %h required %h", cyc, got, exp);
            end
            cyc++;
        end
    endtask

    task automatic test_lw();
        obs_t got, exp;
        int   cyc = 0;
        push(O_LW, 1'b1, 1'b0, E_FETCH);
        push(O_LW, 1'b1, 1'b0, E_DECODE);
        push(O_LW, 1'b1, 1'b0, E_MEMADR);
        push(O_LW, 1'b1, 1'b0, E_MEMRD);
        push(O_LW, 1'b1, 1'b0, E_MEMWB);
        push(O_J,  1'b1, 1'b0, E_FETCH);
        push(O_J,  1'b1, 1'b0, E_DECODE);
        push(O_J,  1'b1, 1'b0, E_JUMP);
        while (expq.size() > 0) begin
            drive(stq.pop_front());
            exp = expq.pop_front();
            got = sample();
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL lw cycle %0d: got %h required %h", cyc, got, exp);
            end
            cyc++;
        end
    endtask

    task automatic test_sw_stall();
        obs_t got, exp;
        int   cyc = 0;
        push(O_SW, 1'b1, 1'b0, E_FETCH);
        push(O_SW, 1'b0, 1'b0, E_DECODE);
        push(O_SW, 1'b0, 1'b0, E_MEMADR);
        push(O_SW, 1'b0, 1'b0, E_MEMWR);
        push(O_SW, 1'b0, 1'b0, E_MEMWR);
        push(O_SW, 1'b0, 1'b0, E_MEMWR);
        push(O_SW, 1'b1, 1'b0, E_MEMWR);
        push(O_J,  1'b0, 1'b0, E_FSTALL);
        push(O_J,  1'b0, 1'b0, E_FSTALL);
        push(O_J,  1'b1, 1'b0, E_FETCH);
        push(O_J,  1'b0, 1'b0, E_DECODE);
        push(O_J,  1'b0, 1'b0, E_JUMP);
        while (expq.size() > 0) begin
            drive(stq.pop_front());
            exp = expq.pop_front();
            got = sample();
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL sw_stall cycle %0d: got %h required %h", cyc, got, exp);
            end
            cyc++;
        end
    endtask

    task automatic test_itype();
        obs_t got, exp;
        int   cyc = 0;
        push(O_ORI,  1'b1, 1'b0, E_FETCH);
        push(O_ORI,  1'b1, 1'b0, E_DECODE);
        push(O_ORI,  1'b1, 1'b0, E_IEX_Z);
        push(O_ADDI, 1'b1, 1'b0, E_IWB_Z);
        push(O_ADDI, 1'b1, 1'b0, E_FETCH);
        push(O_ADDI, 1'b1, 1'b0, E_DECODE);
        push(O_ADDI, 1'b1, 1'b0, E_IEX_S);
        push(O_ORI,  1'b1, 1'b0, E_IWB_S);
        push(O_SLTI, 1'b1, 1'b0, E_FETCH);
        push(O_SLTI, 1'b1, 1'b0, E_DECODE);
        push(O_SLTI, 1'b1, 1'b0, E_IEX_S);
        push(O_SLTI, 1'b1, 1'b0, E_IWB_S);
        while (expq.size() > 0) begin
            drive(stq.pop_front());
            exp = expq.pop_front();
            got = sample();
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL itype cycle %0d: got %h required %h", cyc, got, exp);
            end
            cyc++;
        end
    endtask

    task automatic test_branch_illegal();
        obs_t got, exp;
        int   cyc = 0;
        push(O_BEQ, 1'b1, 1'b0, E_FETCH);
        push(O_BEQ, 1'b1, 1'b0, E_DECODE);
        push(O_BEQ, 1'b1, 1'b0, E_BEQ);
        push(O_BNE, 1'b1, 1'b0, E_FETCH);
        push(O_BNE, 1'b1, 1'b0, E_DECODE);
        push(O_BNE, 1'b1, 1'b0, E_BNE);
        push(O_BAD, 1'b1, 1'b0, E_FETCH);
        push(O_BAD, 1'b1, 1'b0, E_DEC_ILL);
        push(O_J,   1'b1, 1'b0, E_FETCH);
        push(O_J,   1'b1, 1'b0, E_DECODE);
        push(O_J,   1'b1, 1'b0, E_JUMP);
        while (expq.size() > 0) begin
            drive(stq.pop_front());
            exp = expq.pop_front();
            got = sample();
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL branch_illegal cycle %0d: got %h required %h", cyc, got, exp);
            end
            cyc++;
        end
    endtask

    task automatic test_reset_mid();
        obs_t got, exp;
        int   cyc = 0;
        // Reset lands on lw's write-back cycle
        push(O_LW, 1'b1, 1'b0, E_FETCH);
        push(O_LW, 1'b1, 1'b0, E_DECODE);
        push(O_LW, 1'b1, 1'b0, E_MEMADR);
        push(O_LW, 1'b1, 1'b0, E_MEMRD);
        push(O_LW, 1'b1, 1'b1, E_ZERO);
        push(O_LW, 1'b1, 1'b0, E_FETCH);
        push(O_LW, 1'b1, 1'b0, E_DECODE);
        push(O_LW, 1'b1, 1'b0, E_MEMADR);
        push(O_LW, 1'b0, 1'b0, E_MEMRD);
        push(O_LW, 1'b0, 1'b1, E_ZERO);
        push(O_J,  1'b1, 1'b0, E_FETCH);
        push(O_J,  1'b1, 1'b0, E_DECODE);
        push(O_J,  1'b1, 1'b0, E_JUMP);
        push(O_R,  1'b1, 1'b0, E_FETCH);
        while (expq.size() > 0) begin
            drive(stq.pop_front());
            exp = expq.pop_front();
            got = sample();
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL reset_mid cycle %0d: got %h required %h", cyc, got, exp);
            end
            cyc++;
        end
    endtask

    initial begin
        reset     = 1'b1;
        op        = O_R;
        mem_ready = 1'b1;
        test_reset();
        test_lw();
        test_sw_stall();
        test_itype();
        test_branch_illegal();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
